// File: rtl/debug_dump_tx_pkg.sv
// Shared definitions for the debug dump transmitter: header byte, FSM state encoding,
// word-class codes and frame-length helpers.
package debug_dump_tx_pkg;

  localparam logic [7:0] DUMP_HEADER = 8'hA5;

  typedef enum logic [3:0] {
    StIdle,
    StHdr,
    StSel,
    StWait,
    StCap,
    StSend,
    StNext,
    StChk,
    StFin
  } state_e;

  typedef enum logic [1:0] {
    ClsPc,
    ClsLatch,
    ClsReg,
    ClsMem
  } word_cls_e;

  // Bytes on the wire: header + 4 bytes per word + checksum.
  function automatic int unsigned frame_len(int unsigned nl, int unsigned nr, int unsigned nm);
    return 2 + 4 * (1 + nl + nr + nm);
  endfunction

  // Index counter width, sized to the largest word class.
  function automatic int unsigned idx_width(int unsigned nl, int unsigned nr, int unsigned nm);
    int unsigned mx;
    mx = nl;
    if (nr > mx) mx = nr;
    if (nm > mx) mx = nm;
    return (mx <= 1) ? 1 : $clog2(mx);
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter.
//   clk, rst   : clock, synchronous active-high reset
//   in_data    : byte to send
//   in_valid   : byte offered; accepted when in_valid & out_ready
//   out_ready  : can accept a byte (idle, or in the final cycle of a stop bit)
//   TX         : serial out, idle high
module uart_tx_byte #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       out_ready,
  output logic       TX
);

  localparam int unsigned CW = (CLKS_PER_BIT <= 1) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BaudLast = CW'(CLKS_PER_BIT - 1);

  logic          active_q;
  logic [CW-1:0] baud_q;
  logic [3:0]    bit_q;
  logic [9:0]    shift_q;
  logic          last_cycle;

  assign last_cycle = active_q && (bit_q == 4'd9) && (baud_q == BaudLast);
  // Ready in the last stop-bit cycle lets the next start bit follow with no gap.
  assign out_ready  = !active_q || last_cycle;

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '1;
      TX       <= 1'b1;
    end else if (in_valid && out_ready) begin
      active_q <= 1'b1;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= {1'b1, in_data, 1'b0};
      TX       <= 1'b0;
    end else if (active_q) begin
      if (baud_q == BaudLast) begin
        baud_q <= '0;
        if (bit_q == 4'd9) begin
          active_q <= 1'b0;
          TX       <= 1'b1;
        end else begin
          bit_q   <= bit_q + 4'd1;
          shift_q <= {1'b1, shift_q[9:1]};
          TX      <= shift_q[1];
        end
      end else begin
        baud_q <= baud_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/debug_dump_tx.sv
// Debug dump transmitter: on in_start streams HEADER, PC, latch words, register words,
// memory words and an XOR checksum over an 8N1 UART line.
//   in_start                    : one-cycle dump request, honoured only when idle
//   in_pc/in_latch/in_fr_data/in_mem_data : word sources
//   out_latch_sel, out_dbg_addr : read selects sequenced by this block
//   out_debug_on                : high while register/memory words are read
//   out_busy, out_done          : frame in progress / one-cycle end-of-frame pulse
//   TX                          : UART serial out
module debug_dump_tx
  import debug_dump_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned NUM_LATCH    = 24,
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned MEM_WORDS    = 32,
  parameter int unsigned READ_LAT     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_start,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_latch,
  input  logic [31:0] in_fr_data,
  input  logic [31:0] in_mem_data,
  output logic [6:0]  out_latch_sel,
  output logic [31:0] out_dbg_addr,
  output logic        out_debug_on,
  output logic        out_busy,
  output logic        out_done,
  output logic        TX
);

  localparam int unsigned IW = idx_width(NUM_LATCH, NUM_REGS, MEM_WORDS);

  state_e      state_q;
  word_cls_e   cls_q;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] last_idx;
  logic [31:0] word_q;
  logic [31:0] cap_word;
  logic [1:0]  byte_q;
  logic [1:0]  wait_q;
  logic [7:0]  chk_q;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_fire;

  always_comb begin
    last_idx = '0;
    cap_word = in_pc;
    unique case (cls_q)
      ClsPc:    begin last_idx = '0;                 cap_word = in_pc;       end
      ClsLatch: begin last_idx = IW'(NUM_LATCH - 1); cap_word = in_latch;    end
      ClsReg:   begin last_idx = IW'(NUM_REGS - 1);  cap_word = in_fr_data;  end
      ClsMem:   begin last_idx = IW'(MEM_WORDS - 1); cap_word = in_mem_data; end
      default:  ;
    endcase
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'(word_q >> {byte_q, 3'b000});
    case (state_q)
      StHdr:  begin tx_valid = 1'b1; tx_data = DUMP_HEADER; end
      StSend: tx_valid = 1'b1;
      StChk:  begin tx_valid = 1'b1; tx_data = chk_q; end
      default: ;
    endcase
  end

  assign tx_fire = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cls_q         <= ClsPc;
      idx_q         <= '0;
      word_q        <= '0;
      byte_q        <= '0;
      wait_q        <= '0;
      chk_q         <= '0;
      out_latch_sel <= '0;
      out_dbg_addr  <= '0;
      out_debug_on  <= 1'b0;
      out_busy      <= 1'b0;
      out_done      <= 1'b0;
    end else begin
      out_done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (in_start) begin
            out_busy      <= 1'b1;
            out_latch_sel <= '0;
            out_dbg_addr  <= '0;
            chk_q         <= '0;
            cls_q         <= ClsPc;
            idx_q         <= '0;
            state_q       <= StHdr;
          end
        end
        StHdr: if (tx_fire) state_q <= StSel;
        StSel: begin
          case (cls_q)
            ClsLatch:      out_latch_sel <= 7'(idx_q);
            ClsReg, ClsMem: out_dbg_addr <= 32'(idx_q);
            default: ;
          endcase
          wait_q  <= '0;
          state_q <= StWait;
        end
        StWait: begin
          if (wait_q == 2'(READ_LAT - 1)) state_q <= StCap;
          else wait_q <= wait_q + 2'd1;
        end
        StCap: begin
          word_q  <= cap_word;
          byte_q  <= '0;
          state_q <= StSend;
          if (cls_q == ClsMem && idx_q == last_idx) out_debug_on <= 1'b0;
        end
        StSend: begin
          if (tx_fire) begin
            chk_q  <= chk_q ^ tx_data;
            byte_q <= byte_q + 2'd1;
            if (byte_q == 2'd3) state_q <= StNext;
          end
        end
        StNext: begin
          if (idx_q == last_idx) begin
            idx_q <= '0;
            unique case (cls_q)
              ClsPc:    begin cls_q <= ClsLatch; state_q <= StSel; end
              ClsLatch: begin cls_q <= ClsReg; state_q <= StSel; out_debug_on <= 1'b1; end
              ClsReg:   begin cls_q <= ClsMem; state_q <= StSel; end
              ClsMem:   state_q <= StChk;
              default:  state_q <= StChk;
            endcase
          end else begin
            idx_q   <= idx_q + IW'(1);
            state_q <= StSel;
          end
        end
        StChk: if (tx_fire) state_q <= StFin;
        StFin: begin
          // Leave once the checksum stop bit is in its final cycle.
          if (tx_ready) begin
            out_busy <= 1'b0;
            out_done <= 1'b1;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk      (clk),
    .rst      (rst),
    .in_data  (tx_data),
    .in_valid (tx_valid),
    .out_ready(tx_ready),
    .TX       (TX)
  );

endmodule

// File: tb/tb_debug_dump_tx.sv
// Bench for debug_dump_tx: two instances (read latency 1 and 3) share stimulus; a serial
// decoder per instance checks bit timing and compares each byte to a frame model.
module tb_debug_dump_tx;

  localparam int CPB = 4;
  localparam int NL  = 2;
  localparam int NR  = 2;
  localparam int NM  = 2;
  localparam int BYTE_CYC = 10 * CPB;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [31:0] pc = 32'h0000_0013;

  logic [6:0]  sel_a, sel_b;
  logic [31:0] addr_a, addr_b;
  logic [1:0]  on_w, busy_w, done_w, tx_w;
  logic [31:0] lat_a, lat_b, fr_a, fr_b, mem_a, mem_b;

  always #5 clk = ~clk;

  debug_dump_tx #(
    .CLKS_PER_BIT(CPB), .NUM_LATCH(NL), .NUM_REGS(NR), .MEM_WORDS(NM), .READ_LAT(1)
  ) dut_a (
    .clk(clk), .rst(rst), .in_start(start), .in_pc(pc), .in_latch(lat_a),
    .in_fr_data(fr_a), .in_mem_data(mem_a), .out_latch_sel(sel_a), .out_dbg_addr(addr_a),
    .out_debug_on(on_w[0]), .out_busy(busy_w[0]), .out_done(done_w[0]), .TX(tx_w[0])
  );

  debug_dump_tx #(
    .CLKS_PER_BIT(CPB), .NUM_LATCH(NL), .NUM_REGS(NR), .MEM_WORDS(NM), .READ_LAT(3)
  ) dut_b (
    .clk(clk), .rst(rst), .in_start(start), .in_pc(pc), .in_latch(lat_b),
    .in_fr_data(fr_b), .in_mem_data(mem_b), .out_latch_sel(sel_b), .out_dbg_addr(addr_b),
    .out_debug_on(on_w[1]), .out_busy(busy_w[1]), .out_done(done_w[1]), .TX(tx_w[1])
  );

  // Registered source models. Register/memory reads return junk unless debug_on was high
  // when the address was sampled.
  logic [31:0] lp_a, fp_a, mp_a;
  logic [31:0] lp_b [3];
  logic [31:0] fp_b [3];
  logic [31:0] mp_b [3];

  always @(posedge clk) begin
    lp_a <= 32'h1000 + 32'(sel_a);
    fp_a <= on_w[0] ? {27'd0, addr_a[4:0]} : 32'hDEAD_BEEF;
    mp_a <= on_w[0] ? (32'hFFFF_0000 | addr_a) : 32'hBADB_AD00;
    lp_b[0] <= 32'h1000 + 32'(sel_b);
    fp_b[0] <= on_w[1] ? {27'd0, addr_b[4:0]} : 32'hDEAD_BEEF;
    mp_b[0] <= on_w[1] ? (32'hFFFF_0000 | addr_b) : 32'hBADB_AD00;
    for (int s = 1; s < 3; s++) begin
      lp_b[s] <= lp_b[s-1];
      fp_b[s] <= fp_b[s-1];
      mp_b[s] <= mp_b[s-1];
    end
  end

  assign lat_a = lp_a;
  assign fr_a  = fp_a;
  assign mem_a = mp_a;
  assign lat_b = lp_b[2];
  assign fr_b  = fp_b[2];
  assign mem_b = mp_b[2];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model built from the frame rules directly.
  logic [7:0] exp_frame [$];

  task automatic build_model();
    logic [31:0] words [$];
    logic [7:0]  x;
    logic [7:0]  b;
    words.push_back(pc);
    for (int i = 0; i < NL; i++) words.push_back(32'h1000 + 32'(i));
    for (int i = 0; i < NR; i++) words.push_back(32'(i));
    for (int i = 0; i < NM; i++) words.push_back(32'hFFFF_0000 | 32'(i));
    exp_frame.push_back(8'hA5);
    x = 8'h00;
    foreach (words[w]) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'(words[w] >> (8 * k));
        exp_frame.push_back(b);
        x = x ^ b;
      end
    end
    exp_frame.push_back(x);
  endtask

  // Serial decoders and per-cycle monitors.
  int  cyc = 0;
  bit  act [2];
  int  cnt [2];
  bit  smp [2][BYTE_CYC];
  int  exp_idx [2];
  int  exp_len [2];
  logic [7:0] rx_buf [2][64];
  int  t_first [2];
  int  t_done [2];
  int  done_cnt [2];

  task automatic finish_byte(input int k);
    bit ok;
    logic [7:0] d;
    ok = (smp[k][0] == 1'b0) && (smp[k][9*CPB] == 1'b1);
    for (int bt = 0; bt < 10; bt++)
      for (int c = 1; c < CPB; c++)
        if (smp[k][bt*CPB+c] != smp[k][bt*CPB]) ok = 1'b0;
    for (int bt = 0; bt < 8; bt++) d[bt] = smp[k][(bt+1)*CPB];
    check($sformatf("bit_framing[%0d]", k), 32'(ok), 32'd1);
    if (exp_idx[k] < exp_len[k]) begin
      check($sformatf("byte%0d[%0d]", exp_idx[k], k), 32'(d), 32'(exp_frame[exp_idx[k]]));
      rx_buf[k][exp_idx[k]] = d;
    end else begin
      check($sformatf("unexpected_byte[%0d]", k), 32'(d), 32'hFFFF_FFFF);
    end
    exp_idx[k]++;
  endtask

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        act[k] = 1'b0;
      end else begin
        if (!act[k] && tx_w[k] == 1'b0) begin
          act[k] = 1'b1;
          cnt[k] = 0;
          if (exp_idx[k] == 0) t_first[k] = cyc;
        end
        if (act[k]) begin
          smp[k][cnt[k]] = tx_w[k];
          if (cnt[k] == BYTE_CYC - 1) begin
            act[k] = 1'b0;
            finish_byte(k);
          end else begin
            cnt[k]++;
          end
        end
      end
      if (done_w[k]) begin
        done_cnt[k]++;
        t_done[k] = cyc;
        check($sformatf("busy_low_with_done[%0d]", k), 32'(busy_w[k]), 32'd0);
      end
      if (!busy_w[k]) check($sformatf("debug_on_idle[%0d]", k), 32'(on_w[k]), 32'd0);
    end
  end

  task automatic arm(input int len);
    for (int k = 0; k < 2; k++) begin
      exp_idx[k] = 0;
      exp_len[k] = len;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while ((done_cnt[0] < target || done_cnt[1] < target) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("frame_done_timeout", 32'(n < 4000), 32'd1);
  endtask

  task automatic check_frame(input int dbase);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("byte_count[%0d]", k), 32'(exp_idx[k]), 32'd30);
      check($sformatf("done_count[%0d]", k), 32'(done_cnt[k]), 32'(dbase + 1));
      check($sformatf("frame_cycles[%0d]", k), 32'(t_done[k] - t_first[k]), 32'(30 * BYTE_CYC));
      check($sformatf("rx_header[%0d]", k), 32'(rx_buf[k][0]), 32'hA5);
      check($sformatf("rx_chk[%0d]", k), 32'(rx_buf[k][29]), 32'h12);
    end
  endtask

  initial begin
    int n;
    build_model();
    // Hand-computed pins on the model.
    check("model_len", 32'(exp_frame.size()), 32'd30);
    check("model_pc_lsb", 32'(exp_frame[1]), 32'h13);
    check("model_latch0_b1", 32'(exp_frame[6]), 32'h10);
    check("model_mem1_b3", 32'(exp_frame[28]), 32'hFF);
    check("model_chk", 32'(exp_frame[29]), 32'h12);

    arm(0);
    done_cnt[0] = 0;
    done_cnt[1] = 0;
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", 32'(tx_w), 32'h3);
    check("rst_busy", 32'(busy_w), 32'h0);
    check("rst_done", 32'(done_w), 32'h0);
    check("rst_debug_on", 32'(on_w), 32'h0);
    check("rst_latch_sel", {sel_a, sel_b}, 32'h0);
    check("rst_dbg_addr", addr_a | addr_b, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Header timing and full frame.
    arm(30);
    pulse_start();
    check("busy_after_start", 32'(busy_w), 32'h3);
    check("tx_idle_in_hdr", 32'(tx_w), 32'h3);
    @(posedge clk);
    #1 check("tx_start_bit", 32'(tx_w), 32'h0);
    wait_done(1);
    check_frame(0);
    check("rx_latch0_b0", 32'(rx_buf[0][5]), 32'h00);
    check("rx_mem0_b2", 32'(rx_buf[1][23]), 32'hFF);
    check("held_latch_sel", {25'd0, sel_a}, 32'(NL - 1));
    check("held_dbg_addr", addr_b, 32'(NM - 1));

    // Start while busy is ignored.
    arm(30);
    pulse_start();
    check("sel_cleared_at_start", {sel_a, sel_b}, 32'h0);
    check("addr_cleared_at_start", addr_a | addr_b, 32'h0);
    repeat (300) @(posedge clk);
    #1 pulse_start();
    wait_done(2);
    check_frame(1);
    repeat (200) @(posedge clk);
    #1;
    check("no_extra_frame_busy", 32'(busy_w), 32'h0);
    check("no_extra_frame_bytes", 32'(exp_idx[0]), 32'd30);
    check("no_extra_done", 32'(done_cnt[0] + done_cnt[1]), 32'd4);

    // Start coinciding with reset sends nothing.
    arm(0);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    start = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    check("rst_start_busy", 32'(busy_w), 32'h0);
    check("rst_start_bytes", 32'(exp_idx[0] + exp_idx[1]), 32'd0);
    check("rst_start_done", 32'(done_cnt[0] + done_cnt[1]), 32'd4);

    // Reset during byte 10.
    arm(30);
    pulse_start();
    n = 0;
    while (!(exp_idx[0] == 9 && act[0] && cnt[0] > 5) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reach_byte10_timeout", 32'(n < 2000), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_tx", 32'(tx_w), 32'h3);
    check("midrst_busy", 32'(busy_w), 32'h0);
    check("midrst_debug_on", 32'(on_w), 32'h0);
    check("midrst_sel_addr", {sel_a, sel_b} | addr_a | addr_b, 32'h0);
    rst = 1'b0;
    repeat (100) @(posedge clk);
    #1 check("midrst_no_done", 32'(done_cnt[0] + done_cnt[1]), 32'd4);
    arm(30);
    pulse_start();
    wait_done(3);
    check_frame(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
